// File: rtl/riscv_mem_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mem_pkg
// Shared definitions for the RV32I memory-access stage:
//   - funct3 width codes for loads and stores
//   - memory-stage FSM state type {IDLE, REQ, WAIT}
//   - is_misaligned(): natural-alignment check used by the optional
//     misaligned-access trap (MISALIGN_TRAP_EN)
// -----------------------------------------------------------------------------
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_e;

    // Halfword accesses need addr[0]==0, word accesses need addr[1:0]==0.
    // funct3[1:0] carries the access size for both loads and stores, so the
    // unsigned load variants (LBU/LHU) fall out of the same decode.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (funct3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_stage_store_align.sv
// -----------------------------------------------------------------------------
// store_align
// Combinational byte-lane alignment for stores.
// Ports:
//   addr_lo  in   2     low effective-address bits
//   funct3   in   3     store width code (SB/SH/SW)
//   data     in   XLEN  rs2 value
//   mask     out  4     byte-enable mask for the cache
//   din      out  XLEN  store data replicated onto every matching lane
// -----------------------------------------------------------------------------
module store_align
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] data,
    output logic [3:0]      mask,
    output logic [XLEN-1:0] din
);

    // Data is replicated across all lanes so the mask alone selects the
    // destination bytes; no barrel shift of the data is needed.
    always_comb begin
        mask = 4'b0000;
        din  = data;
        case (funct3)
            F3_SB: begin
                mask = 4'b0001 << addr_lo;
                din  = {4{data[7:0]}};
            end
            F3_SH: begin
                mask = 4'b0011 << {addr_lo[1], 1'b0};
                din  = {2{data[15:0]}};
            end
            F3_SW: begin
                mask = 4'b1111;
                din  = data;
            end
            default: begin
                // Undefined store width: no byte lanes enabled.
                mask = 4'b0000;
                din  = data;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Memory stage of the 5-stage RV32I pipeline. Accepts one instruction per
// handshake from execute, issues loads/stores to the data cache over a
// ready/valid interface, stalls upstream while a cache access is pending, and
// presents a registered bundle to writeback.
//
// Optional build macro: MISALIGN_TRAP_EN
//   defined   - misaligned LH/LHU/SH/LW/SW issue no cache request; they retire
//               like non-memory ops with wb_misaligned=1, wb_reg_we=0.
//   undefined - wb_misaligned is tied 0; low address bits are truncated.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   in_valid / in_ready          execute handshake (in_ready only in IDLE)
//   in_pc, in_alu_result         pc and ALU result (effective address)
//   in_store_data                rs2 value for stores
//   in_funct3                    load/store width code
//   in_is_load, in_is_store      memory-op class
//   in_reg_we, in_do_jump, in_rd pass-through controls
//   dcache_re, dcache_we         load request / store byte mask
//   dcache_addr, dcache_din      word address / lane-aligned store data
//   dcache_ready                 cache accepts the request this cycle
//   dcache_valid, dcache_dout    load response
//   wb_valid                     one-cycle pulse: bundle below is valid
//   wb_pc, wb_alu_result,
//   wb_dcache_dout, wb_funct3,
//   wb_reg_we, wb_mem_rr,
//   wb_do_jump, wb_rd            registered writeback bundle
//   wb_misaligned                misaligned-access flag
// -----------------------------------------------------------------------------
module mem_access_stage
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_store_data,
    input  logic [2:0]      in_funct3,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic            in_reg_we,
    input  logic            in_do_jump,
    input  logic [RD_W-1:0] in_rd,

    output logic            dcache_re,
    output logic [3:0]      dcache_we,
    output logic [XLEN-1:0] dcache_addr,
    output logic [XLEN-1:0] dcache_din,
    input  logic            dcache_ready,
    input  logic            dcache_valid,
    input  logic [XLEN-1:0] dcache_dout,

    output logic            wb_valid,
    output logic [XLEN-1:0] wb_pc,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [XLEN-1:0] wb_dcache_dout,
    output logic [2:0]      wb_funct3,
    output logic            wb_reg_we,
    output logic            wb_mem_rr,
    output logic            wb_do_jump,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_misaligned
);

    mem_state_e state;

    // Memory op latched at acceptance; drives the cache request in REQ and
    // supplies the writeback bundle when the access completes.
    logic [XLEN-1:0] op_pc;
    logic [XLEN-1:0] op_addr;
    logic [XLEN-1:0] op_data;
    logic [2:0]      op_funct3;
    logic            op_is_load;
    logic            op_reg_we;
    logic            op_do_jump;
    logic [RD_W-1:0] op_rd;

    logic            accept;
    logic            is_mem;
    logic            trap;
    logic            pass;
    logic            start_mem;
    logic            req_active;
    logic            store_done;
    logic            load_done;
    logic [3:0]      align_mask;
    logic [XLEN-1:0] align_din;

    assign in_ready = (state == IDLE);
    assign accept   = in_ready & in_valid;
    assign is_mem   = in_is_load | in_is_store;

`ifdef MISALIGN_TRAP_EN
    assign trap = is_mem & is_misaligned(in_funct3, in_alu_result[1:0]);
`else
    assign trap = 1'b0;
`endif

    // A trapped memory op retires exactly like a non-memory op.
    assign pass       = accept & (~is_mem | trap);
    assign start_mem  = accept & is_mem & ~trap;
    assign req_active = (state == REQ);
    assign store_done = req_active & dcache_ready & ~op_is_load;
    assign load_done  = (state == WAIT) & dcache_valid;

    store_align #(
        .XLEN (XLEN)
    ) u_store_align (
        .addr_lo (op_addr[1:0]),
        .funct3  (op_funct3),
        .data    (op_data),
        .mask    (align_mask),
        .din     (align_din)
    );

    // Request outputs are decoded from the latched op and the state only, so
    // they stay stable for as long as the cache withholds dcache_ready and
    // drop at once when the async reset forces IDLE.
    assign dcache_re   = req_active & op_is_load;
    assign dcache_we   = (req_active & ~op_is_load) ? align_mask : 4'b0000;
    assign dcache_addr = req_active ? {op_addr[XLEN-1:2], 2'b00} : '0;
    assign dcache_din  = (req_active & ~op_is_load) ? align_din : '0;

    // ---- FSM ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_mem) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (dcache_ready) begin
                        if (op_is_load) begin
                            state <= WAIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                WAIT: begin
                    if (dcache_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- Latched memory op ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_pc      <= '0;
            op_addr    <= '0;
            op_data    <= '0;
            op_funct3  <= '0;
            op_is_load <= 1'b0;
            op_reg_we  <= 1'b0;
            op_do_jump <= 1'b0;
            op_rd      <= '0;
        end else if (start_mem) begin
            op_pc      <= in_pc;
            op_addr    <= in_alu_result;
            op_data    <= in_store_data;
            op_funct3  <= in_funct3;
            op_is_load <= in_is_load;
            op_reg_we  <= in_reg_we;
            op_do_jump <= in_do_jump;
            op_rd      <= in_rd;
        end
    end

    // ---- Writeback bundle ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid       <= 1'b0;
            wb_pc          <= '0;
            wb_alu_result  <= '0;
            wb_dcache_dout <= '0;
            wb_funct3      <= '0;
            wb_reg_we      <= 1'b0;
            wb_mem_rr      <= 1'b0;
            wb_do_jump     <= 1'b0;
            wb_rd          <= '0;
        end else begin
            wb_valid <= pass | store_done | load_done;
            if (pass) begin
                wb_pc         <= in_pc;
                wb_alu_result <= in_alu_result;
                wb_funct3     <= in_funct3;
                wb_reg_we     <= in_reg_we & ~trap;
                wb_mem_rr     <= 1'b0;
                wb_do_jump    <= in_do_jump;
                wb_rd         <= in_rd;
            end else if (store_done | load_done) begin
                wb_pc         <= op_pc;
                wb_alu_result <= op_addr;
                wb_funct3     <= op_funct3;
                wb_reg_we     <= op_reg_we;
                wb_mem_rr     <= load_done;
                wb_do_jump    <= op_do_jump;
                wb_rd         <= op_rd;
            end
            // Raw word only; writeback does byte select and sign extension.
            if (load_done) begin
                wb_dcache_dout <= dcache_dout;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misaligned_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misaligned_q <= 1'b0;
        end else if (pass | store_done | load_done) begin
            misaligned_q <= pass & trap;
        end
    end

    assign wb_misaligned = misaligned_q;
`else
    assign wb_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Randomized bench for mem_access_stage with a transaction-level reference
// model: every accepted instruction predicts one writeback bundle (and, for
// memory ops, one cache request) from the architectural rules. A negedge
// monitor compares the DUT against those predictions on every cycle.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [2:0]  in_funct3;
    logic        in_is_load;
    logic        in_is_store;
    logic        in_reg_we;
    logic        in_do_jump;
    logic [4:0]  in_rd;
    logic        dcache_re;
    logic [3:0]  dcache_we;
    logic [31:0] dcache_addr;
    logic [31:0] dcache_din;
    logic        dcache_ready;
    logic        dcache_valid;
    logic [31:0] dcache_dout;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_dcache_dout;
    logic [2:0]  wb_funct3;
    logic        wb_reg_we;
    logic        wb_mem_rr;
    logic        wb_do_jump;
    logic [4:0]  wb_rd;
    logic        wb_misaligned;

    mem_access_stage #(
        .XLEN (32),
        .RD_W (5)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_alu_result  (in_alu_result),
        .in_store_data  (in_store_data),
        .in_funct3      (in_funct3),
        .in_is_load     (in_is_load),
        .in_is_store    (in_is_store),
        .in_reg_we      (in_reg_we),
        .in_do_jump     (in_do_jump),
        .in_rd          (in_rd),
        .dcache_re      (dcache_re),
        .dcache_we      (dcache_we),
        .dcache_addr    (dcache_addr),
        .dcache_din     (dcache_din),
        .dcache_ready   (dcache_ready),
        .dcache_valid   (dcache_valid),
        .dcache_dout    (dcache_dout),
        .wb_valid       (wb_valid),
        .wb_pc          (wb_pc),
        .wb_alu_result  (wb_alu_result),
        .wb_dcache_dout (wb_dcache_dout),
        .wb_funct3      (wb_funct3),
        .wb_reg_we      (wb_reg_we),
        .wb_mem_rr      (wb_mem_rr),
        .wb_do_jump     (wb_do_jump),
        .wb_rd          (wb_rd),
        .wb_misaligned  (wb_misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] dout;
        logic [2:0]  f3;
        logic        reg_we;
        logic        mem_rr;
        logic        jump;
        logic        mis;
        logic [4:0]  rd;
        int          cyc;
    } wb_t;

    wb_t         exp_q[$];
    wb_t         mon_e;
    logic        busy     = 1'b0;
    logic        req_act  = 1'b0;
    logic        req_load = 1'b0;
    logic [3:0]  req_mask = 4'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_din  = 32'b0;
    logic [31:0] last_dout = 32'b0;
    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Store lane placement from the width rules: byte/half data replicated,
    // mask selects the addressed lanes.
    task automatic store_exp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                             output logic [3:0] m, output logic [31:0] dn);
        int o;
        o = int'(a[1:0]);
        case (f3)
            3'd0: begin m = 4'(1 << o);       dn = {24'b0, d[7:0]} * 32'h01010101; end
            3'd1: begin m = 4'(3 << (o & 2)); dn = {16'b0, d[15:0]} * 32'h00010001; end
            default: begin m = 4'hF;          dn = d; end
        endcase
    endtask

    function automatic logic trap_of(input logic ld, input logic st, input logic [2:0] f3,
                                     input logic [31:0] a);
        logic t;
        t = 1'b0;
`ifdef MISALIGN_TRAP_EN
        t = (ld || st) && ((f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00));
`endif
        return t;
    endfunction

    // Drives one instruction and plays the cache for it. Returns #1 after the
    // edge at which the instruction retires.
    task automatic do_op(input logic ld, input logic st, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [2:0] f3,
                         input logic we, input logic jmp, input logic [4:0] rd,
                         input int rdly, input int vdly, input logic [31:0] rdata);
        wb_t  e;
        logic tr;
        logic [3:0]  m;
        logic [31:0] dn;
        tr = trap_of(ld, st, f3, alu);
        in_valid = 1'b1; in_pc = pc; in_alu_result = alu; in_store_data = sd;
        in_funct3 = f3; in_is_load = ld; in_is_store = st; in_reg_we = we;
        in_do_jump = jmp; in_rd = rd;
        e.pc = pc; e.alu = alu; e.f3 = f3; e.rd = rd; e.jump = jmp;
        @(posedge clk); #1;
        if (!(ld || st) || tr) begin
            e.dout = last_dout; e.reg_we = we && !tr; e.mem_rr = 1'b0; e.mis = tr; e.cyc = cyc;
            exp_q.push_back(e);
            in_valid = 1'b0;
            return;
        end
        store_exp(f3, alu, sd, m, dn);
        busy = 1'b1; req_act = 1'b1; req_load = ld;
        req_addr = {alu[31:2], 2'b00}; req_mask = ld ? 4'b0 : m; req_din = dn;
        // Upstream presents unrelated traffic while stalled; it must be ignored.
        in_valid = 1'($urandom); in_pc = $urandom; in_alu_result = $urandom;
        in_store_data = $urandom; in_funct3 = 3'($urandom); in_is_load = 1'($urandom);
        in_is_store = 1'b0; in_rd = 5'($urandom);
        dcache_ready = 1'b0;
        repeat (rdly) begin
            dcache_valid = 1'($urandom); dcache_dout = $urandom;
            @(posedge clk); #1;
        end
        dcache_valid = 1'b0; dcache_ready = 1'b1;
        @(posedge clk); #1;
        dcache_ready = 1'b0; req_act = 1'b0;
        if (st) begin
            e.dout = last_dout; e.reg_we = we; e.mem_rr = 1'b0; e.mis = 1'b0; e.cyc = cyc;
            exp_q.push_back(e);
        end else begin
            repeat (vdly) begin
                dcache_dout = $urandom;
                @(posedge clk); #1;
            end
            dcache_valid = 1'b1; dcache_dout = rdata;
            @(posedge clk); #1;
            dcache_valid = 1'b0;
            last_dout = rdata;
            e.dout = rdata; e.reg_we = we; e.mem_rr = 1'b1; e.mis = 1'b0; e.cyc = cyc;
            exp_q.push_back(e);
        end
        busy = 1'b0;
        in_valid = 1'b0;
    endtask

    // Per-cycle compare against the model's predictions.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("in_ready", in_ready, !busy);
            chk("dcache_re", dcache_re, req_act && req_load);
            chk("dcache_we", dcache_we, (req_act && !req_load) ? req_mask : 4'b0);
            if (req_act) begin
                chk("dcache_addr", dcache_addr, req_addr);
                if (!req_load) chk("dcache_din", dcache_din, req_din);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
                chk("wb_valid", wb_valid, 1'b1);
                chk("wb_pc", wb_pc, mon_e.pc);
                chk("wb_alu_result", wb_alu_result, mon_e.alu);
                chk("wb_dcache_dout", wb_dcache_dout, mon_e.dout);
                chk("wb_funct3", wb_funct3, mon_e.f3);
                chk("wb_reg_we", wb_reg_we, mon_e.reg_we);
                chk("wb_mem_rr", wb_mem_rr, mon_e.mem_rr);
                chk("wb_do_jump", wb_do_jump, mon_e.jump);
                chk("wb_rd", wb_rd, mon_e.rd);
                chk("wb_misaligned", wb_misaligned, mon_e.mis);
            end else begin
                chk("wb_valid_idle", wb_valid, 1'b0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_wb_valid"}, wb_valid, 0);
        chk({tag, "_wb_pc"}, wb_pc, 0);
        chk({tag, "_wb_alu"}, wb_alu_result, 0);
        chk({tag, "_wb_dout"}, wb_dcache_dout, 0);
        chk({tag, "_wb_misc"}, {wb_funct3, wb_reg_we, wb_mem_rr, wb_do_jump, wb_rd, wb_misaligned}, 0);
        chk({tag, "_dc_re_we"}, {dcache_re, dcache_we}, 0);
        chk({tag, "_dc_addr"}, dcache_addr, 0);
        chk({tag, "_dc_din"}, dcache_din, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    logic [2:0] lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        logic [31:0] a;
        int          kind;
        reset_n = 1'b0; in_valid = 1'b0; in_pc = 0; in_alu_result = 0; in_store_data = 0;
        in_funct3 = 0; in_is_load = 0; in_is_store = 0; in_reg_we = 0; in_do_jump = 0;
        in_rd = 0; dcache_ready = 0; dcache_valid = 0; dcache_dout = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("rst");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Three back-to-back ALU ops.
        for (int i = 0; i < 3; i++) begin
            do_op(0, 0, 32'h100 + 32'(4 * i), 32'h1234, 0, 3'd0, 1, 0, 5'd3, 0, 0, 0);
            chk("add_lit_alu", wb_alu_result, 32'h1234);
            chk("add_lit_valid", wb_valid, 1);
            chk("add_lit_ready", in_ready, 1);
        end
        @(posedge clk); #1;

        // SB to 0x103 with two cycles of backpressure.
        fork
            do_op(0, 1, 32'h200, 32'h103, 32'h000000AB, 3'd0, 0, 0, 5'd0, 2, 0, 0);
            begin
                @(posedge clk); #2;
                chk("sb_lit_we", dcache_we, 4'b1000);
                chk("sb_lit_din", dcache_din, 32'hABABABAB);
                chk("sb_lit_addr", dcache_addr, 32'h100);
            end
        join
        chk("sb_lit_wbv", wb_valid, 1);
        chk("sb_lit_rr", wb_mem_rr, 0);

        // LW 0x200 with the response three cycles after acceptance.
        do_op(1, 0, 32'h204, 32'h200, 0, 3'd2, 1, 0, 5'd7, 0, 2, 32'hDEADBEEF);
        chk("lw_lit_dout", wb_dcache_dout, 32'hDEADBEEF);
        chk("lw_lit_rr", wb_mem_rr, 1);
        chk("lw_lit_wbv", wb_valid, 1);

        // JAL-style pass-through.
        do_op(0, 0, 32'h40, 32'h44, 0, 3'd0, 1, 1, 5'd1, 0, 0, 0);
        chk("jal_lit_jump", wb_do_jump, 1);
        chk("jal_lit_we", wb_reg_we, 1);
        chk("jal_lit_pc", wb_pc, 32'h40);

        // LW to a misaligned address.
        fork
            do_op(1, 0, 32'h300, 32'h202, 0, 3'd2, 1, 0, 5'd9, 1, 0, 32'h0BADF00D);
            begin
                @(posedge clk); #2;
`ifdef MISALIGN_TRAP_EN
                chk("mis_lit_re", dcache_re, 0);
                chk("mis_lit_flag", wb_misaligned, 1);
                chk("mis_lit_we", wb_reg_we, 0);
`else
                chk("mis_lit_re", dcache_re, 1);
                chk("mis_lit_addr", dcache_addr, 32'h200);
                chk("mis_lit_flag", wb_misaligned, 0);
`endif
            end
        join
        @(posedge clk); #1;

        // Reset while a load waits for its response; a late response is ignored.
        in_valid = 1; in_is_load = 1; in_is_store = 0; in_alu_result = 32'h300;
        in_funct3 = 3'd2; in_pc = 32'h500; in_reg_we = 1; in_rd = 5'd4;
        @(posedge clk); #1;
        in_valid = 0; busy = 1; req_act = 1; req_load = 1; req_mask = 0; req_addr = 32'h300;
        dcache_ready = 1;
        @(posedge clk); #1;
        dcache_ready = 0; req_act = 0;
        @(posedge clk); #1;
        chk("wait_lit_ready", in_ready, 0);
        #1;
        reset_n = 1'b0;
        busy = 0; exp_q.delete(); last_dout = 0;
        #1;
        chk_reset_state("midrst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        dcache_valid = 1; dcache_dout = 32'h12345678;
        @(posedge clk); #1;
        dcache_valid = 0;
        chk("late_rsp_wbv", wb_valid, 0);
        @(posedge clk); #1;

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 2);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            case (kind)
                0: do_op(0, 0, $urandom, a, $urandom, 3'($urandom), 1'($urandom), 1'($urandom),
                         5'($urandom), 0, 0, 0);
                1: do_op(1, 0, $urandom, a, $urandom, lf3[$urandom_range(0, 4)], 1'($urandom),
                         1'($urandom), 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom);
                default: do_op(0, 1, $urandom, a, $urandom, 3'($urandom_range(0, 2)),
                               1'($urandom), 1'($urandom), 5'($urandom), $urandom_range(0, 3),
                               0, 0);
            endcase
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("wb_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage RV32I pipeline; sits directly upstream of the writeback stage.
- Accepts one instruction per handshake from execute and issues load/store requests to the data cache over a ready/valid interface.
- Stalls upstream on cache misses.
- Presents a registered, aligned bundle to writeback: pc, alu_result, raw dcache word, funct3, reg_we, mem_rr, do_jump, rd.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RD_W, 5, destination-register index width.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous assert, active-low
- in_valid  in  1  execute presents an instruction
- in_ready  out  1  stage can accept; equals (state==IDLE)
- in_pc  in  32  instruction pc
- in_alu_result  in  32  ALU result; the effective address for memory ops
- in_store_data  in  32  rs2 value for stores
- in_funct3  in  3  load/store width code
- in_is_load, in_is_store  in  1 each  memory-op class; at most one is set
- in_reg_we, in_do_jump  in  1 each  passed through unchanged
- in_rd  in  RD_W  destination register
- dcache_re  out  1  load request
- dcache_we  out  4  store byte mask; nonzero means store request
- dcache_addr  out  32  word address {addr[31:2],2'b00}
- dcache_din  out  32  store data, byte-lane aligned
- dcache_ready  in  1  cache accepts the current request this cycle
- dcache_valid  in  1  load response valid
- dcache_dout  in  32  load response word
- wb_valid  out  1  one-cycle pulse; the writeback bundle is valid
- wb_pc, wb_alu_result, wb_dcache_dout  out  32 each  registered bundle
- wb_funct3  out  3  registered width code
- wb_reg_we, wb_mem_rr, wb_do_jump  out  1 each  registered flags; wb_mem_rr = load
- wb_rd  out  RD_W  registered destination
- wb_misaligned  out  1  misaligned access flag (see Optional Feature)

Behaviour:
- FSM states: IDLE, REQ, WAIT.
- Reset: state=IDLE. Every wb_* output is 0. dcache_re=0, dcache_we=0. dcache_addr and dcache_din are 0.
- IDLE, accept when in_valid&in_ready:
  - Non-memory op: the bundle registers at the edge; wb_valid=1 in the next cycle; state stays IDLE. Throughput is 1 per cycle.
  - Load or store: the op is latched and state moves to REQ. wb_valid=0.
- REQ: request outputs are driven combinationally from the latched op and held stable until dcache_ready=1.
  - Store accepted (dcache_ready=1): wb_valid=1 next cycle with wb_mem_rr=0; state goes to IDLE.
  - Load accepted: state goes to WAIT.
- WAIT: dcache_re=0.
  - On dcache_valid=1: capture dcache_dout into wb_dcache_dout; wb_valid=1 next cycle; state goes to IDLE.
  - The response is never earlier than the cycle after acceptance. dcache_valid in REQ or IDLE is ignored.
- Store alignment, with o=addr[1:0]:
  - SB: mask = 4'b0001<<o, din = {4{data[7:0]}}.
  - SH: mask = 4'b0011<<{o[1],1'b0}, din = {2{data[15:0]}}.
  - SW: mask = 4'b1111, din = data.
- Load data is passed raw. Byte select and sign extension stay in writeback, which uses wb_alu_result[1:0].
- wb_valid is deasserted in every cycle not named above. The wb_* data fields hold their last value.
- Reset mid-operation: the outstanding request is abandoned immediately, because the async reset clears dcache_re and dcache_we. A late dcache_valid is then ignored in IDLE.
- in_ready=0 in REQ and WAIT. Upstream must hold its inputs; inputs are not sampled in those states.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- With the macro: a misaligned access is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - No cache request is issued; the op is handled like a non-memory op.
  - wb_valid=1 next cycle with wb_misaligned=1 and wb_reg_we=0, wb_mem_rr=0.
- Without the macro: wb_misaligned is tied 0. The access is issued with the masking above, and the low address bits are silently truncated.

Decomposition:
- Shared package (riscv_mem_pkg): funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW, the state enum {IDLE,REQ,WAIT}, and a misalignment-check function.
- Sub-module store_align: combinational map from addr[1:0], funct3 and data to mask and din.

Test Plan:
- ADD-type op, alu_result=0x1234, for 3 back-to-back cycles -> in_ready stays 1; wb_valid pulses at cycles 1, 2, 3 with matching wb_alu_result.
- SB addr=0x103, data=0xAB, dcache_ready held low 2 cycles -> dcache_we=4'b1000, din=0xABABABAB, addr=0x100 held stable; wb_valid one cycle after ready.
- LW addr=0x200, ready immediate, dcache_valid 3 cycles later with 0xDEADBEEF -> in_ready=0 throughout; wb_dcache_dout=0xDEADBEEF, wb_mem_rr=1, single wb_valid pulse.
- JAL op with in_reg_we=1, in_do_jump=1, pc=0x40 -> wb_do_jump=1, wb_reg_we=1, wb_pc=0x40 one cycle later.
- reset_n low while in WAIT, then dcache_valid=1 after release -> outputs 0, state IDLE, no wb_valid.
- MISALIGN_TRAP_EN build, LW addr=0x202 -> no dcache_re; wb_misaligned=1, wb_reg_we=0 next cycle. Default build -> dcache_re asserted with addr=0x200.
